// File: rtl/chr_fetch.sv
// CHR fetch stage: synchronises the P-bus strobes, queues one C-ROM and one S-ROM fetch,
// and serves them one at a time through the shared memory arbiter.
module chr_fetch #(
    parameter int SYNC_STAGES = 2,
    parameter int AW          = 26
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pck1b,
    input  logic          pck2b,
    input  logic [23:0]   p,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic          mem_valid,
    input  logic [31:0]   mem_rdata,
    output logic [31:0]   cr,
    output logic          cr_valid,
    output logic [7:0]    fixd,
    output logic          fixd_valid,
    output logic          busy,
    output logic          overrun
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t                 state;
    logic                   kind_c;
    logic                   pend_c;
    logic                   pend_s;
    logic [23:0]            ca;
    logic [15:0]            sa;
    logic [SYNC_STAGES-1:0] c_sync;
    logic [SYNC_STAGES-1:0] s_sync;
    logic [23:0]            p_sync [SYNC_STAGES];

    logic rise_c;
    logic rise_s;
    logic take_c;
    logic take_s;

    // Strobe edge is seen between the two oldest flops of each chain.
    assign rise_c = c_sync[SYNC_STAGES-2] & ~c_sync[SYNC_STAGES-1];
    assign rise_s = s_sync[SYNC_STAGES-2] & ~s_sync[SYNC_STAGES-1];
    assign take_c = (state == IDLE) & pend_c;
    assign take_s = (state == IDLE) & ~pend_c & pend_s;
    assign busy   = (state != IDLE) | pend_c | pend_s;

    function automatic logic [AW-1:0] fit(input logic [25:0] a);
        return AW'(a);
    endfunction

    // NOTE: the synchroniser flops are reset too, so a strobe held high through reset
    // cannot fake an edge on the first cycle after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_sync <= '0;
            s_sync <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) p_sync[i] <= '0;
        end else begin
            c_sync    <= {c_sync[SYNC_STAGES-2:0], pck1b};
            s_sync    <= {s_sync[SYNC_STAGES-2:0], pck2b};
            p_sync[0] <= p;
            for (int i = 1; i < SYNC_STAGES; i++) p_sync[i] <= p_sync[i-1];
        end
    end

    // NOTE: all state here uses non-blocking assignments so every branch reads the
    // pre-edge values of pend_c/ca; mem_addr therefore takes the address that was pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            kind_c     <= 1'b0;
            pend_c     <= 1'b0;
            pend_s     <= 1'b0;
            ca         <= '0;
            sa         <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            cr         <= '0;
            cr_valid   <= 1'b0;
            fixd       <= '0;
            fixd_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            cr_valid   <= 1'b0;
            fixd_valid <= 1'b0;

            // A new edge wins over the clear issued by the IDLE->REQ hand-off.
            if (rise_c) begin
                ca     <= p_sync[SYNC_STAGES-1];
                pend_c <= 1'b1;
                if (pend_c && !take_c) overrun <= 1'b1;
            end else if (take_c) begin
                pend_c <= 1'b0;
            end

            if (rise_s) begin
                sa     <= p_sync[SYNC_STAGES-1][15:0];
                pend_s <= 1'b1;
                if (pend_s && !take_s) overrun <= 1'b1;
            end else if (take_s) begin
                pend_s <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pend_c) begin
                        state    <= REQ;
                        kind_c   <= 1'b1;
                        mem_req  <= 1'b1;
                        mem_addr <= fit({1'b0, ca, 1'b0});
                    end else if (pend_s) begin
                        state    <= REQ;
                        kind_c   <= 1'b0;
                        mem_req  <= 1'b1;
                        mem_addr <= fit({1'b1, 8'h00, sa, 1'b0});
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        state   <= WAIT;
                        mem_req <= 1'b0;
                    end
                end
                WAIT: begin
                    if (mem_valid) begin
                        if (kind_c) begin
                            cr       <= mem_rdata;
                            cr_valid <= 1'b1;
                        end else begin
                            fixd       <= mem_rdata[7:0];
                            fixd_valid <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chr_fetch.sv
// Randomised bench for chr_fetch: a queue-based model predicts each memory request and
// each returned word; a random-latency arbiter answers the requests.
module tb_chr_fetch;

    localparam int AW = 26;

    logic          clk = 1'b0;
    logic          rst;
    logic          pck1b;
    logic          pck2b;
    logic [23:0]   p;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic          mem_valid;
    logic [31:0]   mem_rdata;
    logic [31:0]   cr;
    logic          cr_valid;
    logic [7:0]    fixd;
    logic          fixd_valid;
    logic          busy;
    logic          overrun;

    chr_fetch #(.SYNC_STAGES(2), .AW(AW)) dut (
        .clk(clk), .rst(rst), .pck1b(pck1b), .pck2b(pck2b), .p(p),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata),
        .cr(cr), .cr_valid(cr_valid), .fixd(fixd), .fixd_valid(fixd_valid),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct { bit is_c; logic [AW-1:0] addr; } req_t;
    typedef struct { bit is_c; logic [31:0] d; } rsp_t;

    req_t        req_q[$];
    rsp_t        rsp_q[$];
    logic [31:0] data_q[$];

    int          n_checks = 0;
    int          n_pass   = 0;
    bit          arb_en   = 1'b0;
    bit          hold_ack = 1'b0;
    logic [31:0] exp_cr   = '0;
    logic [7:0]  exp_fixd = '0;
    int          n_cr     = 0;
    int          n_fix    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    endtask

    // Byte address from the address-map rule: C words at 2*p, S bytes at 2^25 + 2*p[15:0].
    function automatic logic [AW-1:0] exp_addr(input bit is_c, input logic [23:0] pv);
        longint a;
        if (is_c) a = longint'(pv) * 2;
        else      a = 64'h200_0000 + longint'(pv[15:0]) * 2;
        return a[AW-1:0];
    endfunction

    task automatic expect_fetch(input bit is_c, input logic [23:0] pv);
        req_t r;
        r.is_c = is_c;
        r.addr = exp_addr(is_c, pv);
        req_q.push_back(r);
    endtask

    task automatic strobe(input bit c, input bit s, input logic [23:0] pv);
        @(negedge clk);
        p = pv;
        repeat (3) @(negedge clk);
        pck1b = c;
        pck2b = s;
        repeat (3) @(negedge clk);
        pck1b = 1'b0;
        pck2b = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_cr   = '0;
        exp_fixd = '0;
        req_q.delete();
        rsp_q.delete();
        data_q.delete();
        n_cr  = 0;
        n_fix = 0;
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        while ((busy || req_q.size() != 0 || rsp_q.size() != 0) && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 1000) check("idle_timeout", 1, 0);
        repeat (2) @(negedge clk);
    endtask

    // Arbiter: acks after 1-10 cycles, returns data in the cycle after the ack.
    initial begin : arbiter
        int          lat;
        req_t        r;
        logic [31:0] d;
        rsp_t        e;
        forever begin
            @(negedge clk);
            if (arb_en && mem_req && !hold_ack && !rst) begin
                lat = $urandom_range(0, 9);
                repeat (lat) @(negedge clk);
                if (req_q.size() == 0) begin
                    check("unexpected_req", 1, 0);
                    r.is_c = 1'b1;
                end else begin
                    r = req_q.pop_front();
                    check("mem_addr", mem_addr, r.addr);
                end
                mem_ack = 1'b1;
                @(negedge clk);
                mem_ack = 1'b0;
                d = (data_q.size() != 0) ? data_q.pop_front() : $urandom;
                e.is_c = r.is_c;
                e.d    = d;
                rsp_q.push_back(e);
                mem_valid = 1'b1;
                mem_rdata = d;
                @(negedge clk);
                mem_valid = 1'b0;
                mem_rdata = $urandom;
            end
        end
    end

    // Output monitor: every pulse must match the oldest outstanding response, in order.
    initial begin : monitor
        rsp_t e;
        forever begin
            @(negedge clk);
            if (cr_valid && fixd_valid) check("dual_pulse", 1, 0);
            if (cr_valid) begin
                n_cr++;
                if (rsp_q.size() == 0) check("unexpected_cr_valid", 1, 0);
                else begin
                    e = rsp_q.pop_front();
                    check("cr_kind", e.is_c, 1);
                    exp_cr = e.d;
                    check("cr", cr, exp_cr);
                    check("fixd_hold", fixd, exp_fixd);
                end
            end else if (fixd_valid) begin
                n_fix++;
                if (rsp_q.size() == 0) check("unexpected_fixd_valid", 1, 0);
                else begin
                    e = rsp_q.pop_front();
                    check("fixd_kind", e.is_c, 0);
                    exp_fixd = e.d[7:0];
                    check("fixd", fixd, exp_fixd);
                    check("cr_hold", cr, exp_cr);
                end
            end
        end
    end

    initial begin : stimulus
        int          cyc;
        logic [23:0] pv;

        rst       = 1'b1;
        pck1b     = 1'b0;
        pck2b     = 1'b0;
        p         = '0;
        mem_ack   = 1'b0;
        mem_valid = 1'b0;
        mem_rdata = '0;
        repeat (3) @(negedge clk);

        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_cr", cr, 0);
        check("rst_cr_valid", cr_valid, 0);
        check("rst_fixd", fixd, 0);
        check("rst_fixd_valid", fixd_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;

        // Reset while waiting for data, then a stale read strobe.
        strobe(1'b1, 1'b0, 24'h111111);
        cyc = 0;
        while (!mem_req && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("t1_req_seen", mem_req, 1);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("t1_busy_wait", busy, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem_valid = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        mem_valid = 1'b0;
        check("t1_cr_valid", cr_valid, 0);
        check("t1_cr", cr, 0);
        check("t1_busy", busy, 0);
        check("t1_mem_req", mem_req, 0);
        repeat (3) @(negedge clk);
        check("t1_cr_late", cr, 0);
        arb_en = 1'b1;

        // Single C fetch.
        expect_fetch(1'b1, 24'h123456);
        data_q.push_back(32'hA5A5F00F);
        strobe(1'b1, 1'b0, 24'h123456);
        wait_idle();
        check("t2_cr", cr, 32'hA5A5F00F);
        check("t2_pulses", n_cr, 1);

        // Single S fetch.
        expect_fetch(1'b0, 24'h00BEEF);
        data_q.push_back(32'h000000C3);
        strobe(1'b0, 1'b1, 24'h00BEEF);
        wait_idle();
        check("t3_fixd", fixd, 8'hC3);
        check("t3_pulses", n_fix, 1);

        // Simultaneous edges: C first, then S.
        n_cr  = 0;
        n_fix = 0;
        expect_fetch(1'b1, 24'h3C5A96);
        expect_fetch(1'b0, 24'h3C5A96);
        strobe(1'b1, 1'b1, 24'h3C5A96);
        wait_idle();
        check("t4_c_pulses", n_cr, 1);
        check("t4_s_pulses", n_fix, 1);
        check("t4_overrun", overrun, 0);

        // Overrun: C stuck in REQ while two S edges arrive.
        hold_ack = 1'b1;
        expect_fetch(1'b1, 24'h0ABCDE);
        strobe(1'b1, 1'b0, 24'h0ABCDE);
        strobe(1'b0, 1'b1, 24'h000011);
        check("t5_no_overrun_yet", overrun, 0);
        strobe(1'b0, 1'b1, 24'h000022);
        check("t5_overrun", overrun, 1);
        check("t5_busy", busy, 1);
        expect_fetch(1'b0, 24'h000022);
        hold_ack = 1'b0;
        wait_idle();
        check("t5_overrun_sticky", overrun, 1);

        // Back-to-back C fetches with random data and latency.
        do_reset();
        check("t6_overrun_clr", overrun, 0);
        for (int i = 0; i < 8; i++) begin
            pv = 24'($urandom);
            expect_fetch(1'b1, pv);
            strobe(1'b1, 1'b0, pv);
            repeat (12) @(negedge clk);
        end
        wait_idle();
        check("t6_pulses", n_cr, 8);
        check("t6_overrun", overrun, 0);
        check("t6_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
